cla_pipe_addsub: RTL and testbench



---
 rtl/cla_pipe_addsub.sv | 194 +++++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 adds the lower half of the operands; stage 2 adds the upper half
// using the registered mid carry, then registers sum, carry-out and signed
// overflow. Both stages advance together under a valid/ready handshake.
// Optional feature macro: CLA_PIPE_SAT_EN clamps the result to the signed
// limit whenever signed overflow occurs (no extra latency).
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             op,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int HALF = WIDTH / 2;
  localparam int NGRP = HALF / GROUP;

  // Full lookahead carries of one GROUP-bit block: every carry is a flat
  // sum of generate terms gated by the propagates above them, plus the
  // block carry-in gated by all lower propagates.
  function automatic logic [GROUP:0] group_carries(
    input logic [GROUP-1:0] g,
    input logic [GROUP-1:0] p,
    input logic             c0
  );
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = c0;
    for (int i = 1; i <= GROUP; i++) begin
      term = c0;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  // One half-width adder: lookahead inside each group, carry rippling from
  // group to group. Returns {carry_out, sum}.
  function automatic logic [HALF:0] half_add(
    input logic [HALF-1:0] x,
    input logic [HALF-1:0] y,
    input logic            cin
  );
    logic [HALF-1:0]  g;
    logic [HALF-1:0]  p;
    logic [HALF-1:0]  sum;
    logic [GROUP:0]   c;
    logic             carry;
    g     = x & y;
    p     = x ^ y;
    sum   = '0;
    carry = cin;
    for (int n = 0; n < NGRP; n++) begin
      c = group_carries(g[n*GROUP +: GROUP], p[n*GROUP +: GROUP], carry);
      sum[n*GROUP +: GROUP] = p[n*GROUP +: GROUP] ^ c[GROUP-1:0];
      carry = c[GROUP];
    end
    return {carry, sum};
  endfunction

  // Pipeline state.
  logic            valid1_q, valid1_d;
  logic [HALF-1:0] lo_sum_q, lo_sum_d;
  logic            c_mid_q, c_mid_d;
  logic [HALF-1:0] a_hi_q, a_hi_d;
  logic [HALF-1:0] bx_hi_q, bx_hi_d;
  logic            o_valid_q, o_valid_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic            co_q, co_d;
  logic            ovf_q, ovf_d;

  // Combinational intermediates.
  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             cin;
  logic [HALF:0]    lo_res;
  logic [HALF:0]    hi_res;
  logic [WIDTH-1:0] wrap_sum;
  logic [WIDTH-1:0] final_sum;
  logic             carry_into_msb;
  logic             co_n;
  logic             ovf_n;

  // Whole pipe moves when the output slot is empty or being drained.
  always_comb begin
    adv = ~o_valid_q | o_ready;
  end

  assign i_ready = adv;

  // Operand conditioning and the lower-half addition feeding stage 1.
  always_comb begin
    bx     = op ? ~b : b;
    cin    = op ? 1'b1 : ci;
    lo_res = half_add(a[HALF-1:0], bx[HALF-1:0], cin);
  end

  // Stage 1 next state: capture lower sum, mid carry and the upper operands.
  always_comb begin
    valid1_d = valid1_q;
    lo_sum_d = lo_sum_q;
    c_mid_d  = c_mid_q;
    a_hi_d   = a_hi_q;
    bx_hi_d  = bx_hi_q;
    if (adv) begin
      valid1_d = i_valid;
      lo_sum_d = lo_res[HALF-1:0];
      c_mid_d  = lo_res[HALF];
      a_hi_d   = a[WIDTH-1:HALF];
      bx_hi_d  = bx[WIDTH-1:HALF];
    end
  end

  // Upper-half addition, flags and optional saturation for stage 2.
  always_comb begin
    hi_res         = half_add(a_hi_q, bx_hi_q, c_mid_q);
    wrap_sum       = {hi_res[HALF-1:0], lo_sum_q};
    co_n           = hi_res[HALF];
    carry_into_msb = hi_res[HALF-1] ^ a_hi_q[HALF-1] ^ bx_hi_q[HALF-1];
    ovf_n          = carry_into_msb ^ co_n;
`ifdef CLA_PIPE_SAT_EN
    if (ovf_n) begin
      final_sum = a_hi_q[HALF-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      final_sum = wrap_sum;
    end
`else
    final_sum = wrap_sum;
`endif
  end

  // Stage 2 next state: load the result when the pipe advances, else hold.
  always_comb begin
    o_valid_d = o_valid_q;
    s_d       = s_q;
    co_d      = co_q;
    ovf_d     = ovf_q;
    if (adv) begin
      o_valid_d = valid1_q;
      s_d       = final_sum;
      co_d      = co_n;
      ovf_d     = ovf_n;
    end
  end

  // Pipeline registers with synchronous reset clearing every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_q  <= 1'b0;
      lo_sum_q  <= '0;
      c_mid_q   <= 1'b0;
      a_hi_q    <= '0;
      bx_hi_q   <= '0;
      o_valid_q <= 1'b0;
      s_q       <= '0;
      co_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      valid1_q  <= valid1_d;
      lo_sum_q  <= lo_sum_d;
      c_mid_q   <= c_mid_d;
      a_hi_q    <= a_hi_d;
      bx_hi_q   <= bx_hi_d;
      o_valid_q <= o_valid_d;
      s_q       <= s_d;
      co_q      <= co_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_valid = o_valid_q;
  assign s       = s_q;
  assign co      = co_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub: directed, table-driven bench for cla_pipe_addsub
// (WIDTH = 32, GROUP = 4), plus hand-written back-pressure and
// mid-flight reset sequences.
module tb_cla_pipe_addsub;

  localparam int W = 32;

`ifdef CLA_PIPE_SAT_EN
  localparam logic [W-1:0] POS_OVF_S = 32'h7FFF_FFFF;
  localparam logic [W-1:0] NEG_OVF_S = 32'h8000_0000;
`else
  localparam logic [W-1:0] POS_OVF_S = 32'h8000_0000;
  localparam logic [W-1:0] NEG_OVF_S = 32'h0000_0000;
`endif
`ifdef CLA_PIPE_SAT_EN
  localparam logic [W-1:0] NEG_OVF2_S = 32'h8000_0000;
`else
  localparam logic [W-1:0] NEG_OVF2_S = 32'h7FFF_FFFF;
`endif

  logic         clk;
  logic         rst;
  logic         i_valid;
  logic         i_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         op;
  logic         o_valid;
  logic         o_ready;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;

  int n_compared;
  int n_mismatched;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         op;
    logic [W-1:0] exp_s;
    logic         exp_co;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[13];

  cla_pipe_addsub #(.WIDTH(W), .GROUP(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .a       (a),
    .b       (b),
    .ci      (ci),
    .op      (op),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .s       (s),
    .co      (co),
    .ovf     (ovf)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Presents one beat at a falling edge; the next rising edge accepts it.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               input logic tci, input logic top);
    @(negedge clk);
    a       = ta;
    b       = tb_v;
    ci      = tci;
    op      = top;
    i_valid = 1'b1;
    #1;
  endtask

  // Waits (bounded) for o_valid after a beat and returns the latency in cycles.
  task automatic waitResult(output int lat, output bit got);
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      i_valid = 1'b0;
      lat++;
      #1;
      if (o_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  lat;
    bit  got;
    int  n_in;
    int  n_out;
    int  stall_cycles;
    logic [W-1:0] held_s;
    logic [W-1:0] exp_stream[4];

    n_compared   = 0;
    n_mismatched = 0;
    rst     = 1'b1;
    i_valid = 1'b0;
    a       = '0;
    b       = '0;
    ci      = 1'b0;
    op      = 1'b0;
    o_ready = 1'b1;

    // a, b, ci, op, expected s, co, ovf
    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0};
    vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, POS_OVF_S,     1'b0, 1'b1};
    vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[5]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[6]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, NEG_OVF2_S,    1'b1, 1'b1};
    vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, NEG_OVF_S,     1'b1, 1'b1};
    vecs[8]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[9]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[10] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[11] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[12] = '{32'h0000_FFFF, 32'hFFFF_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_o_valid", {63'd0, o_valid}, 64'd0);
    checkOutput("reset_s",       {32'd0, s},       64'd0);
    checkOutput("reset_co",      {63'd0, co},      64'd0);
    checkOutput("reset_ovf",     {63'd0, ovf},     64'd0);
    checkOutput("reset_i_ready", {63'd0, i_ready}, 64'd1);

    // Table: one beat at a time, full throughput downstream.
    for (int v = 0; v < 13; v++) begin
      applyStimulus(vecs[v].a, vecs[v].b, vecs[v].ci, vecs[v].op);
      checkOutput($sformatf("v%0d_i_ready", v), {63'd0, i_ready}, 64'd1);
      waitResult(lat, got);
      if (!got) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL v%0d_timeout: got no o_valid, expected one within 8 cycles", v);
      end else begin
        checkOutput($sformatf("v%0d_latency", v), 64'(lat), 64'd2);
        checkOutput($sformatf("v%0d_s", v),   {32'd0, s},   {32'd0, vecs[v].exp_s});
        checkOutput($sformatf("v%0d_co", v),  {63'd0, co},  {63'd0, vecs[v].exp_co});
        checkOutput($sformatf("v%0d_ovf", v), {63'd0, ovf}, {63'd0, vecs[v].exp_ovf});
      end
    end

    // Drain any leftover state before the streaming test.
    repeat (3) @(negedge clk);

    // Back-pressure: four back-to-back beats, downstream stalls in cycles 2..4.
    exp_stream[0] = 32'd2;
    exp_stream[1] = 32'd4;
    exp_stream[2] = 32'd6;
    exp_stream[3] = 32'd8;
    n_in = 0;
    n_out = 0;
    stall_cycles = 0;
    held_s = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      o_ready = !(c >= 2 && c < 5);
      if (n_in < 4) begin
        a       = W'(n_in + 1);
        b       = W'(n_in + 1);
        ci      = 1'b0;
        op      = 1'b0;
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (o_valid && !o_ready) begin
        if (stall_cycles == 0) held_s = s;
        else checkOutput($sformatf("bp_hold_s_c%0d", c), {32'd0, s}, {32'd0, held_s});
        checkOutput($sformatf("bp_i_ready_c%0d", c), {63'd0, i_ready}, 64'd0);
        stall_cycles++;
      end
      if (o_valid && o_ready) begin
        if (n_out < 4)
          checkOutput($sformatf("bp_result%0d", n_out), {32'd0, s}, {32'd0, exp_stream[n_out]});
        else
          checkOutput("bp_extra_result", 64'(n_out), 64'd3);
        n_out++;
      end
      if (i_valid && i_ready) n_in++;
      if (n_out >= 4 && n_in >= 4 && c > 12) break;
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    checkOutput("bp_results_seen", 64'(n_out), 64'd4);
    checkOutput("bp_stall_cycles", 64'(stall_cycles), 64'd3);
    checkOutput("bp_held_value",   {32'd0, held_s}, 64'd2);

    repeat (3) @(negedge clk);

    // Reset mid-flight: two beats accepted, then reset for one cycle.
    applyStimulus(32'h10, 32'h1, 1'b0, 1'b0);
    applyStimulus(32'h20, 32'h2, 1'b0, 1'b0);
    @(negedge clk);
    i_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstmid_o_valid", {63'd0, o_valid}, 64'd0);
    checkOutput("rstmid_s",       {32'd0, s},       64'd0);
    checkOutput("rstmid_i_ready", {63'd0, i_ready}, 64'd1);
    a       = 32'h100;
    b       = 32'h23;
    ci      = 1'b0;
    op      = 1'b0;
    i_valid = 1'b1;
    waitResult(lat, got);
    if (!got) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL rstmid_timeout: got no o_valid, expected one within 8 cycles");
    end else begin
      checkOutput("rstmid_latency", 64'(lat), 64'd2);
      checkOutput("rstmid_s_post",  {32'd0, s}, 64'h123);
    end
    @(negedge clk);
    #1;
    checkOutput("rstmid_no_extra", {63'd0, o_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
